// File: rtl/data_mem_arbiter_pkg.sv
// rtl/data_mem_arbiter_pkg.sv - MemoryBus shared types for the data memory and its arbiter
// Purpose: command/result types for the byte-masked data memory, plus the
//          arbiter's port identifier.
// Contents: Cmd (write data + byte mask), Result (read word), ArbPort.
package MemoryBus;

    // Write data and per-byte write mask; mask bit i enables data byte i.
    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  mask;
    } Cmd;

    // Read word returned by the memory one cycle after the address.
    typedef logic [31:0] Result;

    // Requester identity: port 0 is the CPU load/store unit, port 1 the DMA/debug master.
    typedef enum logic {PORT_CPU, PORT_DMA} ArbPort;

endpackage

// File: rtl/data_mem_arbiter_starve_counter.sv
// rtl/data_mem_arbiter_starve_counter.sv - saturating wait counter with clear and limit flag
// Purpose: counts consecutive refused cycles of the low-priority port.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   clr_i         clear to zero (wins over increment)
//   inc_i         increment, saturating at LIMIT
//   at_limit_o    count has reached LIMIT
module starve_counter #(
    parameter int unsigned LIMIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic inc_i,
    output logic at_limit_o
);

    localparam logic [7:0] LIMIT_C = 8'(LIMIT);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = 8'd0;
        end else if (inc_i && (cnt_q != LIMIT_C)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_limit_o = (cnt_q == LIMIT_C);

endmodule

// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - two-port arbiter in front of the single-port data memory
// Purpose: grants one access per cycle (port 0 priority, port 1 starvation
//          guard), drives the memory request and routes the one-cycle-late
//          read result back to the port that issued the read.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   pN_valid/pN_ready           per-port request handshake
//   pN_addr/pN_we/pN_cmd        per-port word address, write enable, write command
//   pN_rsp_valid, rsp_data      read response strobe per port, shared data
//   mem_addr/mem_we/mem_cmd     request to the memory
//   mem_rdata                   memory read data, one cycle after the address
module data_mem_arbiter
    import MemoryBus::*;
#(
    parameter int unsigned WIDTH        = 10,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               p0_valid,
    output logic               p0_ready,
    input  logic [WIDTH-3:0]   p0_addr,
    input  logic               p0_we,
    input  Cmd                 p0_cmd,
    input  logic               p1_valid,
    output logic               p1_ready,
    input  logic [WIDTH-3:0]   p1_addr,
    input  logic               p1_we,
    input  Cmd                 p1_cmd,
    output logic               p0_rsp_valid,
    output logic               p1_rsp_valid,
    output logic [31:0]        rsp_data,
    output logic [WIDTH-3:0]   mem_addr,
    output logic               mem_we,
    output Cmd                 mem_cmd,
    input  Result              mem_rdata
);

    logic   p1_at_limit;
    logic   grant0;
    logic   grant1;
    logic   rsp_pend_q;
    logic   rsp_pend_d;
    ArbPort rsp_owner_q;
    ArbPort rsp_owner_d;

    starve_counter #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (!p1_valid || grant1),
        .inc_i      (p1_valid && !grant1),
        .at_limit_o (p1_at_limit)
    );

    // Grants are suppressed while reset is asserted so nothing reaches the
    // memory during reset, even with requests already present.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (rst_n) begin
            if (p1_valid && p1_at_limit) begin
                grant1 = 1'b1;
            end else if (p0_valid) begin
                grant0 = 1'b1;
            end else if (p1_valid) begin
                grant1 = 1'b1;
            end
        end
    end

    assign p0_ready = grant0;
    assign p1_ready = grant1;

    // Port 0 owns the address/command lines unless port 1 is granted.
    always_comb begin
        mem_addr = grant1 ? p1_addr : p0_addr;
        mem_cmd  = grant1 ? p1_cmd  : p0_cmd;
        mem_we   = (grant0 && p0_we) || (grant1 && p1_we);
    end

    // A response slot is opened for every accepted read; reads back-to-back
    // simply reload it each cycle, which keeps the pipeline at one per cycle.
    always_comb begin
        rsp_pend_d  = (grant0 && !p0_we) || (grant1 && !p1_we);
        rsp_owner_d = grant1 ? PORT_DMA : PORT_CPU;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_pend_q  <= 1'b0;
            rsp_owner_q <= PORT_CPU;
        end else begin
            rsp_pend_q  <= rsp_pend_d;
            rsp_owner_q <= rsp_owner_d;
        end
    end

    assign p0_rsp_valid = rsp_pend_q && (rsp_owner_q == PORT_CPU);
    assign p1_rsp_valid = rsp_pend_q && (rsp_owner_q == PORT_DMA);
    assign rsp_data     = mem_rdata;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb/tb_data_mem_arbiter.sv - directed self-checking bench for data_mem_arbiter
module tb_data_mem_arbiter;
    import MemoryBus::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        p0_valid, p0_ready, p0_we;
    logic        p1_valid, p1_ready, p1_we;
    logic [7:0]  p0_addr, p1_addr, mem_addr;
    Cmd          p0_cmd, p1_cmd, mem_cmd;
    logic        p0_rsp_valid, p1_rsp_valid, mem_we;
    logic [31:0] rsp_data;
    Result       mem_rdata;

    logic [31:0] mem [0:255];
    int          n_checks = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    data_mem_arbiter #(.WIDTH(10), .STARVE_LIMIT(4)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .p0_valid     (p0_valid),
        .p0_ready     (p0_ready),
        .p0_addr      (p0_addr),
        .p0_we        (p0_we),
        .p0_cmd       (p0_cmd),
        .p1_valid     (p1_valid),
        .p1_ready     (p1_ready),
        .p1_addr      (p1_addr),
        .p1_we        (p1_we),
        .p1_cmd       (p1_cmd),
        .p0_rsp_valid (p0_rsp_valid),
        .p1_rsp_valid (p1_rsp_valid),
        .rsp_data     (rsp_data),
        .mem_addr     (mem_addr),
        .mem_we       (mem_we),
        .mem_cmd      (mem_cmd),
        .mem_rdata    (mem_rdata)
    );

    // Byte-masked single-port memory with registered read.
    always @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_cmd.mask[b]) mem[mem_addr][8*b +: 8] <= mem_cmd.data[8*b +: 8];
            end
        end
        mem_rdata <= mem[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic set_p0(input logic v, input logic we, input logic [7:0] a,
                          input logic [31:0] d, input logic [3:0] m);
        p0_valid = v; p0_we = we; p0_addr = a; p0_cmd = '{data: d, mask: m};
    endtask

    task automatic set_p1(input logic v, input logic we, input logic [7:0] a,
                          input logic [31:0] d, input logic [3:0] m);
        p1_valid = v; p1_we = we; p1_addr = a; p1_cmd = '{data: d, mask: m};
    endtask

    task automatic mid;
        @(negedge clk);
    endtask

    task automatic next;
        @(posedge clk); #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem_rdata = 32'h0;
        rst_n = 1'b0;
        set_p0(1'b1, 1'b1, 8'd9, 32'hAAAAAAAA, 4'hF);
        set_p1(1'b1, 1'b1, 8'd9, 32'hBBBBBBBB, 4'hF);

        // Reset state with requests present
        mid;
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_p0_ready", 32'(p0_ready), 32'd0);
        check("rst_p1_ready", 32'(p1_ready), 32'd0);
        check("rst_p0_rsp", 32'(p0_rsp_valid), 32'd0);
        check("rst_p1_rsp", 32'(p1_rsp_valid), 32'd0);
        mid;
        p0_valid = 1'b0; p1_valid = 1'b0; rst_n = 1'b1;
        next;

        // Port 0 write then read addr 5, then a write right behind the read
        set_p0(1'b1, 1'b1, 8'd5, 32'hDEADBEEF, 4'hF);
        mid;
        check("t1_wr_ready", 32'(p0_ready), 32'd1);
        check("t1_wr_we", 32'(mem_we), 32'd1);
        check("t1_wr_addr", 32'(mem_addr), 32'd5);
        next;
        set_p0(1'b1, 1'b0, 8'd5, 32'h0, 4'h0);
        mid;
        check("t1_rd_ready", 32'(p0_ready), 32'd1);
        check("t1_rd_we", 32'(mem_we), 32'd0);
        check("t1_rd_p0rsp_early", 32'(p0_rsp_valid), 32'd0);
        next;
        set_p0(1'b1, 1'b1, 8'd5, 32'h12345678, 4'hF);
        mid;
        check("t1_p0_rsp", 32'(p0_rsp_valid), 32'd1);
        check("t1_p1_rsp", 32'(p1_rsp_valid), 32'd0);
        check("t1_rsp_data", rsp_data, 32'hDEADBEEF);
        check("t1_wr2_ready", 32'(p0_ready), 32'd1);
        next;
        set_p0(1'b0, 1'b0, 8'd0, 32'h0, 4'h0);
        mid;
        check("t1_wr_no_rsp", 32'(p0_rsp_valid), 32'd0);
        next;

        // Byte mask
        set_p0(1'b1, 1'b1, 8'd6, 32'hFFFFFFFF, 4'hF);
        next;
        set_p0(1'b1, 1'b1, 8'd6, 32'h11223344, 4'b0101);
        next;
        set_p0(1'b1, 1'b0, 8'd6, 32'h0, 4'h0);
        next;
        set_p0(1'b0, 1'b0, 8'd0, 32'h0, 4'h0);
        mid;
        check("bm_rsp", 32'(p0_rsp_valid), 32'd1);
        check("bm_data", rsp_data, 32'hFF22FF44);
        next;

        // Preload addr 1..3
        set_p0(1'b1, 1'b1, 8'd1, 32'hA1A1A1A1, 4'hF); next;
        set_p0(1'b1, 1'b1, 8'd2, 32'hB2B2B2B2, 4'hF); next;
        set_p0(1'b1, 1'b1, 8'd3, 32'hC3C3C3C3, 4'hF); next;

        // Pipelined mixed reads; port 1 waits until forced
        set_p1(1'b1, 1'b0, 8'd2, 32'h0, 4'h0);
        for (int c = 0; c < 3; c++) begin
            set_p0(1'b1, 1'b1, 8'd0, 32'h0, 4'h0);
            mid;
            check("pl_p1_wait", 32'(p1_ready), 32'd0);
            next;
        end
        set_p0(1'b1, 1'b0, 8'd1, 32'h0, 4'h0);
        mid;
        check("pl_a_p0_ready", 32'(p0_ready), 32'd1);
        check("pl_a_p1_ready", 32'(p1_ready), 32'd0);
        next;
        set_p0(1'b1, 1'b0, 8'd3, 32'h0, 4'h0);
        mid;
        check("pl_b_p1_ready", 32'(p1_ready), 32'd1);
        check("pl_b_p0_ready", 32'(p0_ready), 32'd0);
        check("pl_b_p0_rsp", 32'(p0_rsp_valid), 32'd1);
        check("pl_b_data", rsp_data, 32'hA1A1A1A1);
        next;
        p1_valid = 1'b0;
        mid;
        check("pl_c_p0_ready", 32'(p0_ready), 32'd1);
        check("pl_c_p1_rsp", 32'(p1_rsp_valid), 32'd1);
        check("pl_c_p0_rsp", 32'(p0_rsp_valid), 32'd0);
        check("pl_c_data", rsp_data, 32'hB2B2B2B2);
        next;
        p0_valid = 1'b0;
        mid;
        check("pl_d_p0_rsp", 32'(p0_rsp_valid), 32'd1);
        check("pl_d_p1_rsp", 32'(p1_rsp_valid), 32'd0);
        check("pl_d_data", rsp_data, 32'hC3C3C3C3);
        next;

        // Reset mid-read: the accepted p1 read must never respond
        set_p1(1'b1, 1'b0, 8'd2, 32'h0, 4'h0);
        mid;
        check("rr_p1_ready", 32'(p1_ready), 32'd1);
        #2;
        rst_n = 1'b0;
        set_p0(1'b1, 1'b1, 8'd7, 32'h55555555, 4'hF);
        next;
        mid;
        check("rr_p1_rsp", 32'(p1_rsp_valid), 32'd0);
        check("rr_mem_we", 32'(mem_we), 32'd0);
        check("rr_p0_ready", 32'(p0_ready), 32'd0);
        p0_valid = 1'b0; p1_valid = 1'b0; rst_n = 1'b1;
        next;
        mid;
        check("rr_p1_rsp_after", 32'(p1_rsp_valid), 32'd0);
        next;

        // Build up the wait count, then reset it away
        set_p0(1'b1, 1'b1, 8'd0, 32'h0, 4'h0);
        set_p1(1'b1, 1'b0, 8'd2, 32'h0, 4'h0);
        next; next; next;
        rst_n = 1'b0;
        next;
        rst_n = 1'b1;

        // Starvation under continuous traffic: p1 on cycles 5 and 10
        for (int c = 1; c <= 10; c++) begin
            mid;
            check($sformatf("st_p1_ready_c%0d", c), 32'(p1_ready), 32'((c == 5) || (c == 10)));
            check($sformatf("st_p0_ready_c%0d", c), 32'(p0_ready), 32'(!((c == 5) || (c == 10))));
            check($sformatf("st_p1_rsp_c%0d", c), 32'(p1_rsp_valid), 32'(c == 6));
            if (c == 6) check("st_rsp_data", rsp_data, 32'hB2B2B2B2);
            next;
        end
        p0_valid = 1'b0; p1_valid = 1'b0;
        next;

        // Idle
        for (int c = 0; c < 10; c++) begin
            mid;
            check("idle_mem_we", 32'(mem_we), 32'd0);
            check("idle_ready", 32'({p0_ready, p1_ready}), 32'd0);
            check("idle_rsp", 32'({p0_rsp_valid, p1_rsp_valid}), 32'd0);
            next;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
